// File: rtl/mips_mc_core_if.sv
// Instruction/data bus and retire-trace bundle for the multi-cycle MIPS core.
// master = core side, slave = memory / environment side.
interface mips_mc_core_if #(
    parameter int DM_ADDR_W = 32
);
    logic                 imem_req;
    logic [31:0]          imem_addr;
    logic                 imem_ack;
    logic [31:0]          imem_rdata;
    logic                 dmem_req;
    logic                 dmem_we;
    logic [DM_ADDR_W-1:0] dmem_addr;
    logic [31:0]          dmem_wdata;
    logic                 dmem_ack;
    logic [31:0]          dmem_rdata;
    logic                 retire;
    logic [31:0]          retire_pc;
    logic                 halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata,
        output retire, retire_pc, halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata,
        input  retire, retire_pc, halted
    );
endinterface

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core (FETCH/DECODE/EXEC/MEM/WB) with req/ack instruction
// and data buses; any illegal condition parks the core in HALT until reset.
module mips_mc_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          DM_ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    mips_mc_core_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] retire_pc_q, retire_pc_d;
    logic [31:0] gpr_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire;
    logic        legal;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, imm_zext, pc_plus4, br_target, j_target, eff_addr;

    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext  = {16'h0000, ir_q[15:0]};
    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign eff_addr  = a_q + imm_sext;

    // The all-zero word is the only legal sll; any other funct-0 word halts.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: legal = (ir_q == 32'h0) ||
                              (funct == FN_JR)   || (funct == FN_ADDU) ||
                              (funct == FN_SUBU) || (funct == FN_SLT);
            OP_J, OP_JAL, OP_BEQ, OP_ADDIU, OP_ORI,
            OP_LUI, OP_LW, OP_SW:  legal = 1'b1;
            default:               legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_d       = alu_q;
        retire_pc_d = retire_pc_q;
        rf_we       = 1'b0;
        rf_waddr    = 5'd0;
        rf_wdata    = 32'd0;
        retire      = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = gpr_q[rs];
                b_d     = gpr_q[rt];
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADDU: alu_d = a_q + b_q;
                            FN_SUBU: alu_d = a_q - b_q;
                            FN_SLT:  alu_d = {31'd0, ($signed(a_q) < $signed(b_q))};
                            FN_JR: begin
                                if (a_q[1:0] != 2'b00) begin
                                    state_d = S_HALT;
                                end else begin
                                    pc_d    = a_q;
                                    retire  = 1'b1;
                                    state_d = S_FETCH;
                                end
                            end
                            default: alu_d = 32'd0;
                        endcase
                    end
                    OP_ADDIU: alu_d = a_q + imm_sext;
                    OP_ORI:   alu_d = a_q | imm_zext;
                    OP_LUI:   alu_d = {ir_q[15:0], 16'h0000};
                    OP_LW, OP_SW: begin
                        alu_d   = eff_addr;
                        state_d = (eff_addr[1:0] != 2'b00) ? S_HALT : S_MEM;
                    end
                    OP_BEQ: begin
                        pc_d    = (a_q == b_q) ? br_target : pc_plus4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_J, OP_JAL: begin
                        pc_d     = j_target;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                        rf_we    = (opcode == OP_JAL);
                        rf_waddr = 5'd31;
                        rf_wdata = pc_plus4;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end else begin
                        alu_d   = bus.dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata = alu_q;
                retire   = 1'b1;
                pc_d     = pc_plus4;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        if (retire) begin
            retire_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            alu_q       <= 32'd0;
            retire_pc_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_q       <= alu_d;
            retire_pc_q <= retire_pc_d;
        end
    end

    // $0 is never written, so reads of it always return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= 32'd0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            gpr_q[rf_waddr] <= rf_wdata;
        end
    end

    // imem_req/imem_addr are gated by reset so nothing is driven while rst is low.
    assign bus.imem_req   = rst && (state_q == S_FETCH);
    assign bus.imem_addr  = rst ? pc_q : 32'd0;
    assign bus.dmem_req   = (state_q == S_MEM);
    assign bus.dmem_we    = (state_q == S_MEM) && (opcode == OP_SW);
    assign bus.dmem_addr  = alu_q[DM_ADDR_W-1:0];
    assign bus.dmem_wdata = b_q;
    assign bus.retire     = retire;
    assign bus.retire_pc  = retire ? pc_q : retire_pc_q;
    assign bus.halted     = (state_q == S_HALT);
endmodule

// File: tb/tb_mips_mc_core.sv
// Self-checking bench for mips_mc_core: variable-latency memory models plus a
// scoreboard of expected retires and stores consumed as the core produces them.
module tb_mips_mc_core;
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } ret_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cyc;
    int   iwait;
    int   dwait;
    int   icnt;
    int   dcnt;
    logic mem_load;

    logic [31:0] imem      [64];
    logic [31:0] dmem      [64];
    logic [31:0] dmem_init [64];
    logic [31:0] ioff;

    ret_t ret_q[$];
    st_t  st_q[$];

    mips_mc_core_if #(.DM_ADDR_W(32)) bus ();

    mips_mc_core #(
        .RESET_PC (32'h0000_3000),
        .DM_ADDR_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired: simulation did not finish within 500000 time units");
        $fatal(1, "[TB] watchdog");
    end

    // Memory models: ack after a programmable number of wait cycles.
    always_comb begin
        ioff           = bus.imem_addr - 32'h0000_3000;
        bus.imem_ack   = bus.imem_req && (icnt >= iwait);
        bus.imem_rdata = (ioff < 32'd256) ? imem[ioff[7:2]] : 32'hFC00_0000;
        bus.dmem_ack   = bus.dmem_req && (dcnt >= dwait);
        bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];
    end

    always @(posedge clk) begin
        if (!rst || !bus.imem_req || bus.imem_ack) icnt <= 0;
        else                                       icnt <= icnt + 1;
        if (!rst || !bus.dmem_req || bus.dmem_ack) dcnt <= 0;
        else                                       dcnt <= dcnt + 1;
        if (mem_load) begin
            dmem <= dmem_init;
        end else if (rst && bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
            dmem[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Scoreboard consumer: every retire and every completed store is popped and compared.
    always @(negedge clk) begin
        ret_t r;
        st_t  s;
        if (rst) begin
            if (bus.retire) begin
                checks++;
                if (ret_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL retire_extra got pc=%h, required no retire", bus.retire_pc);
                end else begin
                    r = ret_q.pop_front();
                    if (bus.retire_pc !== r.pc || (r.cyc >= 0 && cyc !== r.cyc)) begin
                        errors++;
                        $display("[TB] FAIL retire got pc=%h cyc=%0d, required pc=%h cyc=%0d",
                                 bus.retire_pc, cyc, r.pc, r.cyc);
                    end
                end
            end
            if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
                checks++;
                if (st_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL store_extra got addr=%h data=%h, required no store",
                             bus.dmem_addr, bus.dmem_wdata);
                end else begin
                    s = st_q.pop_front();
                    if (bus.dmem_addr !== s.addr || bus.dmem_wdata !== s.data) begin
                        errors++;
                        $display("[TB] FAIL store got addr=%h data=%h, required addr=%h data=%h",
                                 bus.dmem_addr, bus.dmem_wdata, s.addr, s.data);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin
            imem[i]      = 32'hFC00_0000;
            dmem_init[i] = 32'd0;
        end
        ret_q.delete();
        st_q.delete();
    endtask

    task automatic exp_ret(input logic [31:0] pc, input int c);
        ret_t r;
        r.pc  = pc;
        r.cyc = c;
        ret_q.push_back(r);
    endtask

    task automatic exp_st(input logic [31:0] addr, input logic [31:0] data);
        st_t s;
        s.addr = addr;
        s.data = data;
        st_q.push_back(s);
    endtask

    task automatic start_run();
        rst      = 1'b0;
        mem_load = 1'b1;
        repeat (3) @(negedge clk);
        mem_load = 1'b0;
        rst      = 1'b1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n;
        n = 0;
        while ((ret_q.size() != 0 || st_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (ret_q.size() == 0 && st_q.size() == 0);
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        int n;
        n = 0;
        while (bus.halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.halted === 1'b1);
    endtask

    task automatic applyStimulus_idle();
        iwait    = 0;
        dwait    = 0;
        mem_load = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        clear_prog();
        rst      = 1'b0;
        mem_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.imem_req, bus.dmem_req, bus.dmem_we, bus.retire, bus.halted} !== 5'b0 ||
                bus.imem_addr !== 32'd0 || bus.retire_pc !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs got req=%b dreq=%b we=%b ret=%b halt=%b addr=%h rpc=%h, required all 0",
                         bus.imem_req, bus.dmem_req, bus.dmem_we, bus.retire, bus.halted,
                         bus.imem_addr, bus.retire_pc);
            end
        end
        mem_load = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_req got %b, required 1", bus.imem_req);
        end
        checks++;
        if (bus.imem_addr !== 32'h0000_3000) begin
            errors++;
            $display("[TB] FAIL reset_release_addr got %h, required 00003000", bus.imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        bit ok;
        clear_prog();
        iwait = 0;
        dwait = 0;
        imem[0]  = enc_i(6'h0D, 5'd0, 5'd1, 16'h00FF);
        imem[1]  = enc_i(6'h0F, 5'd0, 5'd2, 16'h1234);
        imem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
        imem[3]  = enc_r(5'd1, 5'd2, 5'd4, 6'h23);
        imem[4]  = enc_r(5'd4, 5'd1, 5'd5, 6'h2A);
        imem[5]  = enc_r(5'd1, 5'd1, 5'd0, 6'h21);
        imem[6]  = enc_i(6'h09, 5'd0, 5'd6, 16'hFFFF);
        imem[7]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0020);
        imem[8]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0024);
        imem[9]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0028);
        imem[10] = enc_i(6'h2B, 5'd0, 5'd0, 16'h002C);
        imem[11] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0030);
        imem[12] = 32'h0000_0000;
        for (int k = 0; k < 13; k++) begin
            exp_ret(32'h0000_3000 + 32'(4 * k), 3 + 4 * k);
        end
        exp_st(32'h20, 32'h1234_00FF);
        exp_st(32'h24, 32'hEDCC_00FF);
        exp_st(32'h28, 32'h0000_0001);
        exp_st(32'h2C, 32'h0000_0000);
        exp_st(32'h30, 32'hFFFF_FFFF);
        start_run();
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL alu_drain got %0d retires and %0d stores outstanding, required 0",
                     ret_q.size(), st_q.size());
        end
        wait_halt(40, ok);
        checks++;
        if (!ok || bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_halt got halted=%b ireq=%b dreq=%b, required 1 0 0",
                     bus.halted, bus.imem_req, bus.dmem_req);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_memory_waits();
        bit ok;
        int n;
        int w;
        clear_prog();
        iwait = 1;
        dwait = 3;
        imem[0] = enc_i(6'h0D, 5'd0, 5'd6, 16'h0010);
        imem[1] = enc_i(6'h0F, 5'd0, 5'd3, 16'h1234);
        imem[2] = enc_i(6'h0D, 5'd3, 5'd3, 16'h00FF);
        imem[3] = enc_i(6'h2B, 5'd6, 5'd3, 16'hFFFC);
        imem[4] = enc_i(6'h23, 5'd6, 5'd7, 16'hFFFC);
        imem[5] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0030);
        imem[6] = enc_i(6'h23, 5'd0, 5'd8, 16'h0002);
        for (int k = 0; k < 6; k++) begin
            exp_ret(32'h0000_3000 + 32'(4 * k), -1);
        end
        exp_st(32'h0C, 32'h1234_00FF);
        exp_st(32'h30, 32'h1234_00FF);
        start_run();
        n = 0;
        while (bus.dmem_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.dmem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mem_req_timeout got dmem_req=%b, required 1", bus.dmem_req);
        end
        w = 0;
        while (bus.dmem_req === 1'b1 && bus.dmem_ack !== 1'b1 && w < 20) begin
            checks++;
            if (bus.dmem_addr !== 32'h0C || bus.dmem_we !== 1'b1 || bus.dmem_wdata !== 32'h1234_00FF) begin
                errors++;
                $display("[TB] FAIL mem_hold got addr=%h we=%b wdata=%h, required 0000000c 1 123400ff",
                         bus.dmem_addr, bus.dmem_we, bus.dmem_wdata);
            end
            @(negedge clk);
            w++;
        end
        checks++;
        if (w !== 3) begin
            errors++;
            $display("[TB] FAIL mem_wait_cycles got %0d, required 3", w);
        end
        wait_drain(300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL mem_drain got %0d retires and %0d stores outstanding, required 0",
                     ret_q.size(), st_q.size());
        end
        wait_halt(60, ok);
        checks++;
        if (!ok || bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mem_misaligned_halt got halted=%b ireq=%b dreq=%b, required 1 0 0",
                     bus.halted, bus.imem_req, bus.dmem_req);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_control_flow();
        bit ok;
        clear_prog();
        iwait = 0;
        dwait = 0;
        imem[0]  = enc_j(6'h03, 26'h000_0C10);
        imem[16] = enc_i(6'h0D, 5'd0, 5'd1, 16'h0005);
        imem[17] = enc_i(6'h04, 5'd0, 5'd1, 16'h0004);
        imem[18] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
        imem[1]  = enc_i(6'h2B, 5'd0, 5'd31, 16'h0040);
        imem[2]  = enc_j(6'h02, 26'h000_0C08);
        imem[8]  = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
        exp_ret(32'h3000, 2);
        exp_ret(32'h3040, 6);
        exp_ret(32'h3044, 9);
        exp_ret(32'h3048, 12);
        exp_ret(32'h3004, 16);
        exp_ret(32'h3008, 19);
        exp_ret(32'h3020, 22);
        exp_ret(32'h3020, 25);
        exp_ret(32'h3020, 28);
        exp_st(32'h40, 32'h0000_3004);
        start_run();
        wait_drain(100, ok);
        rst = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL ctrl_drain got %0d retires and %0d stores outstanding, required 0",
                     ret_q.size(), st_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_halt();
        bit ok;
        for (int k = 0; k < 3; k++) begin
            clear_prog();
            iwait = 0;
            dwait = 0;
            case (k)
                0: imem[0] = 32'hFC00_0000;
                1: begin
                    imem[0] = enc_i(6'h0D, 5'd0, 5'd2, 16'h3001);
                    imem[1] = enc_r(5'd2, 5'd0, 5'd0, 6'h08);
                    exp_ret(32'h3000, 3);
                end
                default: imem[0] = enc_r(5'd0, 5'd1, 5'd1, 6'h00) | 32'h0000_0040;
            endcase
            start_run();
            wait_halt(40, ok);
            checks++;
            if (!ok || bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0) begin
                errors++;
                $display("[TB] FAIL halt_%0d got halted=%b ireq=%b dreq=%b, required 1 0 0",
                         k, bus.halted, bus.imem_req, bus.dmem_req);
            end
            repeat (6) @(negedge clk);
            checks++;
            if (bus.halted !== 1'b1 || ret_q.size() != 0) begin
                errors++;
                $display("[TB] FAIL halt_sticky_%0d got halted=%b pending=%0d, required 1 0",
                         k, bus.halted, ret_q.size());
            end
            rst = 1'b0;
            #1;
            checks++;
            if (bus.halted !== 1'b0) begin
                errors++;
                $display("[TB] FAIL halt_reset_clear_%0d got %b, required 0", k, bus.halted);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_mem();
        int n;
        clear_prog();
        iwait = 0;
        dwait = 20;
        dmem_init[20] = 32'hDEAD_BEEF;
        imem[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'h0077);
        imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0050);
        exp_ret(32'h3000, 3);
        start_run();
        n = 0;
        while (bus.dmem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.dmem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midmem_req_timeout got %b, required 1", bus.dmem_req);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midmem_req_drop got dreq=%b ireq=%b, required 0 0",
                     bus.dmem_req, bus.imem_req);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dmem[20] !== 32'hDEAD_BEEF || ret_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL midmem_no_write got mem=%h pending=%0d, required deadbeef 0",
                     dmem[20], ret_q.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        applyStimulus_idle();
        test_reset();
        test_alu();
        test_memory_waits();
        test_control_flow();
        test_halt();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_mc_core.md
Name: mips_mc_core

Overview:
Multi-cycle, parametrised successor to the single-cycle MIPS top. It replaces the embedded im/dm with external instruction and data buses that use req/ack handshakes, so memory latency is variable. The instruction set is extended with addiu, slt, jal and jr. Trace outputs (retire/halted) let benches check execution without probing internals.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded at reset; imem_addr is a byte address.
DM_ADDR_W, 32, width of dmem_addr; the low DM_ADDR_W bits of the effective address.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch byte address (= PC)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = store (sw), 0 = load (lw)
dmem_addr  out  DM_ADDR_W  data byte address
dmem_wdata  out  32  store data (rt)
dmem_ack  in  1  access complete; dmem_rdata valid for loads
dmem_rdata  in  32  load data
retire  out  1  one-cycle pulse per completed instruction
retire_pc  out  32  PC of the retiring instruction, valid with retire
halted  out  1  sticky; core stopped on an illegal condition

Behaviour:
- Reset (rst low, async):
  - PC = RESET_PC, GPR[0..31] = 0, state = FETCH.
  - All outputs are 0 while rst is low, including imem_req, dmem_req, retire and halted.
  - imem_req rises in the first cycle after rst goes high.
  - Reset mid-transaction abandons it; req drops asynchronously and nothing is written.
- Handshake:
  - req and addr/we/wdata are held stable until a rising edge with req && ack.
  - ack may be combinational (same cycle as req), giving zero wait states.
  - Data is captured on the req && ack edge; req deasserts on the next cycle unless a new request is issued.
  - ack while req is low is ignored.
- States and transitions:
  - FETCH (imem_req=1, imem_addr=PC): wait for ack; latch IR -> DECODE.
  - DECODE: latch A = GPR[rs], B = GPR[rt]; illegal IR -> HALT.
  - EXEC: compute ALU result / effective address / branch target.
    - ALU ops -> WB.
    - lw/sw -> MEM, except address[1:0] != 0 -> HALT.
    - beq, j, jal, jr: update PC, pulse retire -> FETCH.
  - MEM: hold dmem_req; on ack, sw pulses retire -> FETCH; lw latches data -> WB.
  - WB: write the destination register (writes to $0 discarded), pulse retire -> FETCH.
  - HALT: halted=1, both reqs 0, no retire; leave only through reset.
- Minimum cycles with zero-wait ack: ALU ops 4, lw 5, sw 4, beq/j/jal/jr 3. The nop word 32'h0000_0000 takes 4 cycles (F, D, E, W) and retires without a write.
- Encodings:
  - R-type (op 0x00) funct: addu 0x21, subu 0x23, slt 0x2A, jr 0x08, nop = all-zero word.
  - opcodes: addiu 0x09, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
  - Anything else, including non-zero sll, is illegal -> HALT.
- Arithmetic:
  - addu/subu/addiu wrap modulo 2^32, with no overflow trap.
  - slt is a signed compare giving 1 or 0.
  - ori zero-extends imm16; lui = imm16 << 16.
  - addiu and lw/sw offsets sign-extend imm16.
- Next PC:
  - Default PC+4.
  - beq taken: PC+4 + (sext(imm16) << 2).
  - j/jal: {PC+4[31:28], index26, 2'b00}; jal writes GPR[31] = PC+4 during EXEC.
  - jr: PC = A; A[1:0] != 0 -> HALT.
- Register reads see every write from prior instructions; there is no overlap, so no hazards.
- retire_pc holds its last value between pulses.

Test Plan:
- Reset release: rst low 3 cycles, then high -> imem_req=1, imem_addr=0x3000 on the first post-reset cycle; all outputs 0 during reset.
- ALU sequence at zero wait: ori $1,$0,0x00FF; lui $2,0x1234; addu $3,$1,$2; subu $4,$1,$2; slt $5,$4,$1 -> $3=0x123400FF, $4=0xEDCC00FF, $5=1; retire every 4 cycles at PCs 0x3000..0x3010.
- Memory with waits: ack after 3 cycles; sw $3,-4($6) with $6=0x10 -> dmem_addr=0xC, we=1, wdata=0x123400FF held stable until ack; lw $7,-4($6) -> $7=0x123400FF.
- Control flow: beq $0,$0,-1 at 0x3020 -> next fetch at 0x3020. jal to index 0x0000C10 -> PC=0x3040, $31=PC+4. jr $31 returns to PC+4. beq not taken -> PC+4.
- Illegal/halt: opcode 0x3F, lw to address 0x2, or jr to 0x3001 -> halted=1, both reqs 0, no further retire; reset clears halted.
- Edge cases: addu $0,$1,$1 leaves $0=0; reset asserted mid-MEM wait -> dmem_req drops immediately and no write occurs.
